// File: rtl/data_bus_arbiter_if.sv
// data_bus_arbiter_if: two requesting masters plus the shared data-memory port.
// The slave modport is the arbiter's view; master is the view of the masters and memory.
interface data_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int NB_COL     = DATA_WIDTH / 8
);
    logic                  m0_req, m1_req;
    logic [ADDR_WIDTH-1:0] m0_addr, m1_addr;
    logic [NB_COL-1:0]     m0_wbe, m1_wbe;
    logic [DATA_WIDTH-1:0] m0_wdata, m1_wdata;
    logic                  m0_gnt, m1_gnt;
    logic                  m0_rvalid, m1_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata, m1_rdata;
    logic                  mem_ce;
    logic [NB_COL-1:0]     mem_wbe;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [7:0]            hold_cnt;
    logic [1:0]            owner;

    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_wbe, m1_wbe, m0_wdata, m1_wdata, mem_rdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
               mem_ce, mem_wbe, mem_addr, mem_wdata, hold_cnt, owner
    );

    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_wbe, m1_wbe, m0_wdata, m1_wdata, mem_rdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
               mem_ce, mem_wbe, mem_addr, mem_wdata, hold_cnt, owner
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: fixed-priority two-master data-memory arbiter; master 0 wins unless
// master 1 has waited through MAX_HOLD consecutive master-0 grants.
module data_bus_arbiter #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int NB_COL     = DATA_WIDTH / 8,
    parameter int MAX_HOLD   = 8
) (
    input logic               clk,
    input logic               rst,
    data_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, M0 = 2'd1, M1 = 2'd2} owner_e;

    owner_e                owner_q, owner_d;
    logic [7:0]            hold_q, hold_d;
    logic [1:0]            rd_pend_q, rd_pend_d;
    logic                  force1, gnt0, gnt1;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NB_COL-1:0]     wbe;
    logic [DATA_WIDTH-1:0] wdata;

    // Grants are masked by rst so nothing reaches memory while reset is held.
    always_comb begin
        force1    = bus.m1_req && (hold_q >= 8'(MAX_HOLD));
        gnt1      = !rst && bus.m1_req && (!bus.m0_req || force1);
        gnt0      = !rst && bus.m0_req && !gnt1;
        addr      = gnt0 ? bus.m0_addr : gnt1 ? bus.m1_addr : '0;
        wbe       = gnt0 ? bus.m0_wbe : gnt1 ? bus.m1_wbe : '0;
        wdata     = gnt0 ? bus.m0_wdata : gnt1 ? bus.m1_wdata : '0;
        owner_d   = gnt0 ? M0 : gnt1 ? M1 : IDLE;
        hold_d    = (gnt1 || !bus.m1_req) ? 8'd0 :
                    (gnt0 && hold_q != 8'hFF) ? hold_q + 8'd1 : hold_q;
        rd_pend_d = {gnt1 && bus.m1_wbe == '0, gnt0 && bus.m0_wbe == '0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= IDLE;
            hold_q    <= '0;
            rd_pend_q <= '0;
        end else begin
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.mem_ce    = gnt0 | gnt1;
    assign bus.mem_addr  = addr;
    assign bus.mem_wbe   = wbe;
    assign bus.mem_wdata = wdata;
    assign bus.m0_rvalid = rd_pend_q[0];
    assign bus.m1_rvalid = rd_pend_q[1];
    assign bus.m0_rdata  = bus.mem_rdata;
    assign bus.m1_rdata  = bus.mem_rdata;
    assign bus.hold_cnt  = hold_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed stimulus pushes expected grants/reads into queues;
// a negedge monitor pops and compares whenever the arbiter presents a grant or rvalid.
module tb_data_bus_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int NC = 4;
    localparam int MH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_COL(NC)) bus ();

    data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_COL(NC), .MAX_HOLD(MH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic          who;
        logic [AW-1:0] addr;
        logic [NC-1:0] wbe;
        logic [DW-1:0] wdata;
    } gexp_t;

    typedef struct {
        logic          who;
        logic [DW-1:0] data;
    } rexp_t;

    gexp_t         gq[$];
    rexp_t         rq[$];
    gexp_t         g;
    rexp_t         r;
    int            vectors = 0;
    int            miscompares = 0;
    logic          prev0 = 1'b0;
    logic          prev1 = 1'b0;
    logic [DW-1:0] mem [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: word i powers up as A50000ii; read data appears the cycle after ce.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
            bus.mem_rdata <= '0;
        end else if (bus.mem_ce) begin
            if (bus.mem_wbe == '0) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
            else for (int b = 0; b < NC; b++)
                if (bus.mem_wbe[b]) mem[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("owner", {62'd0, bus.owner}, prev1 ? 64'd2 : prev0 ? 64'd1 : 64'd0);
                if (prev1) chk("hold_after_m1", {56'd0, bus.hold_cnt}, 64'd0);
            end
            if (bus.m0_gnt || bus.m1_gnt) begin
                chk("gnt_excl", {63'd0, bus.m0_gnt & bus.m1_gnt}, 64'd0);
                if (gq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL gnt_unexpected: m0_gnt=%b m1_gnt=%b expected no grant at %0t",
                             bus.m0_gnt, bus.m1_gnt, $time);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_who", {63'd0, bus.m1_gnt}, {63'd0, g.who});
                    chk("mem_ce", {63'd0, bus.mem_ce}, 64'd1);
                    chk("mem_addr", {34'd0, bus.mem_addr}, {34'd0, g.addr});
                    chk("mem_wbe", {60'd0, bus.mem_wbe}, {60'd0, g.wbe});
                    chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, g.wdata});
                end
            end else begin
                chk("idle_ce", {63'd0, bus.mem_ce}, 64'd0);
                chk("idle_addr", {34'd0, bus.mem_addr}, 64'd0);
                chk("idle_wbe_wdata", {28'd0, bus.mem_wbe, bus.mem_wdata}, 64'd0);
            end
            if (bus.m0_rvalid || bus.m1_rvalid) begin
                chk("rvalid_excl", {63'd0, bus.m0_rvalid & bus.m1_rvalid}, 64'd0);
                if (rq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rvalid_unexpected: m0_rvalid=%b m1_rvalid=%b expected none at %0t",
                             bus.m0_rvalid, bus.m1_rvalid, $time);
                end else begin
                    r = rq.pop_front();
                    chk("rvalid_who", {63'd0, bus.m1_rvalid}, {63'd0, r.who});
                    chk("m0_rdata", {32'd0, bus.m0_rdata}, {32'd0, r.data});
                    chk("m1_rdata", {32'd0, bus.m1_rdata}, {32'd0, r.data});
                end
            end
            prev0 = rst ? 1'b0 : bus.m0_gnt;
            prev1 = rst ? 1'b0 : bus.m1_gnt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_wbe = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_wbe = '0; bus.m1_wdata = '0;
    endtask

    task automatic req(input logic who, input logic [AW-1:0] a, input logic [NC-1:0] w,
                       input logic [DW-1:0] d);
        if (who) begin
            bus.m1_req = 1'b1; bus.m1_addr = a; bus.m1_wbe = w; bus.m1_wdata = d;
        end else begin
            bus.m0_req = 1'b1; bus.m0_addr = a; bus.m0_wbe = w; bus.m0_wdata = d;
        end
    endtask

    task automatic expect_gnt(input logic who, input logic [AW-1:0] a, input logic [NC-1:0] w,
                              input logic [DW-1:0] d);
        gq.push_back('{who: who, addr: a, wbe: w, wdata: d});
    endtask

    task automatic expect_rd(input logic who, input logic [DW-1:0] d);
        rq.push_back('{who: who, data: d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_reqs();
        // Both masters requesting through reset.
        req(1'b0, 30'd1, 4'b0000, 32'h0000_1111);
        req(1'b1, 30'd2, 4'b0000, 32'h2222_0000);
        repeat (2) step();
        @(negedge clk);
        chk("rst_m0_gnt", {63'd0, bus.m0_gnt}, 64'd0);
        chk("rst_m1_gnt", {63'd0, bus.m1_gnt}, 64'd0);
        chk("rst_mem_ce", {63'd0, bus.mem_ce}, 64'd0);
        chk("rst_rvalid", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, 64'd0);
        chk("rst_mem_addr", {34'd0, bus.mem_addr}, 64'd0);
        chk("rst_wbe_wdata", {28'd0, bus.mem_wbe, bus.mem_wdata}, 64'd0);
        chk("rst_rdata", {bus.m1_rdata, bus.m0_rdata}, {bus.mem_rdata, bus.mem_rdata});
        // Contention with MAX_HOLD=3: M0,M0,M0,M1 twice, every access a read.
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) begin
                expect_gnt(1'b1, 30'd2, 4'b0000, 32'h2222_0000);
                expect_rd(1'b1, 32'hA500_0002);
            end else begin
                expect_gnt(1'b0, 30'd1, 4'b0000, 32'h0000_1111);
                expect_rd(1'b0, 32'hA500_0001);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) step();
        clear_reqs();
        step();
        // Single-master read by M1.
        req(1'b1, 30'h10, 4'b0000, 32'h1234_5678);
        expect_gnt(1'b1, 30'h10, 4'b0000, 32'h1234_5678);
        expect_rd(1'b1, 32'hA500_0010);
        step();
        clear_reqs();
        // M0 half-word write then M1 read-back of the same word.
        req(1'b0, 30'd5, 4'b0011, 32'hDEAD_BEEF);
        expect_gnt(1'b0, 30'd5, 4'b0011, 32'hDEAD_BEEF);
        step();
        clear_reqs();
        req(1'b1, 30'd5, 4'b0000, 32'h0);
        expect_gnt(1'b1, 30'd5, 4'b0000, 32'h0);
        expect_rd(1'b1, 32'hA500_BEEF);
        step();
        clear_reqs();
        // M1 write: granted but no rvalid.
        req(1'b1, 30'd20, 4'b1000, 32'h7700_0000);
        expect_gnt(1'b1, 30'd20, 4'b1000, 32'h7700_0000);
        step();
        clear_reqs();
        // Back-to-back reads M1 then M0.
        req(1'b1, 30'd7, 4'b0000, 32'h0);
        expect_gnt(1'b1, 30'd7, 4'b0000, 32'h0);
        expect_rd(1'b1, 32'hA500_0007);
        step();
        clear_reqs();
        req(1'b0, 30'd8, 4'b0000, 32'h0);
        expect_gnt(1'b0, 30'd8, 4'b0000, 32'h0);
        expect_rd(1'b0, 32'hA500_0008);
        step();
        clear_reqs();
        repeat (2) step();
        // Reset lands between an M0 read grant and its rvalid edge.
        req(1'b0, 30'd9, 4'b0000, 32'h0);
        expect_gnt(1'b0, 30'd9, 4'b0000, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        clear_reqs();
        @(posedge clk);
        @(negedge clk);
        chk("midrd_rvalid_in_rst", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrd_rd_pend", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, 64'd0);
        chk("midrd_hold", {56'd0, bus.hold_cnt}, 64'd0);
        chk("midrd_owner", {62'd0, bus.owner}, 64'd0);
        repeat (3) step();
        chk("gq_drained", 64'(gq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
